// File: rtl/control_if.sv
// Decode bus between the instruction fetch side and the control unit.
// The master drives the instruction fields and irq. The slave (control) returns the datapath selects.
interface control_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       irq;
  logic [2:0] PCSrc;
  logic [1:0] RegDst;
  logic       RegWrite;
  logic       ALUSrc1;
  logic       ALUSrc2;
  logic [5:0] ALUFun;
  logic       Sign;
  logic       MemRead;
  logic       MemWrite;
  logic [1:0] MemtoReg;
  logic       ExtOp;
  logic       LuOp;

  modport master (
    output OpCode, Funct, irq,
    input  PCSrc, RegDst, RegWrite, ALUSrc1, ALUSrc2, ALUFun, Sign,
           MemRead, MemWrite, MemtoReg, ExtOp, LuOp
  );

  modport slave (
    input  OpCode, Funct, irq,
    output PCSrc, RegDst, RegWrite, ALUSrc1, ALUSrc2, ALUFun, Sign,
           MemRead, MemWrite, MemtoReg, ExtOp, LuOp
  );
endinterface

// File: rtl/control.sv
// Single-cycle MIPS-subset main decoder with a registered interrupt request.
// Optional macro CONTROL_UNDEF_EXCEPTION_EN traps undefined encodings to the exception vector instead of executing a NOP.
module control (
  input  logic     clk,
  input  logic     reset,
  control_if.slave ctrl
);

  typedef enum logic [5:0] {
    ALU_ADD  = 6'b000000,
    ALU_SUB  = 6'b000001,
    ALU_AND  = 6'b011000,
    ALU_OR   = 6'b011110,
    ALU_XOR  = 6'b010110,
    ALU_NOR  = 6'b010001,
    ALU_PASS = 6'b011010,
    ALU_SLL  = 6'b100000,
    ALU_SRL  = 6'b100001,
    ALU_SRA  = 6'b100011,
    ALU_EQ   = 6'b110011,
    ALU_NEQ  = 6'b110001,
    ALU_LT   = 6'b110101,
    ALU_LEZ  = 6'b111101,
    ALU_LTZ  = 6'b111011,
    ALU_GTZ  = 6'b111111
  } aluFunT;

  logic r_irqQ;

  logic   w_rArith;
  logic   w_rShift;
  logic   w_jr;
  logic   w_jalr;
  logic   w_iArith;
  logic   w_zeroExt;
  logic   w_lui;
  logic   w_lw;
  logic   w_sw;
  logic   w_branch;
  logic   w_j;
  logic   w_jal;
  logic   w_unsigned;
  logic   w_defined;
  aluFunT w_aluFun;

  logic [2:0] w_pcSrc;
  logic [1:0] w_regDst;
  logic       w_regWrite;
  logic       w_aluSrc1;
  logic       w_aluSrc2;
  logic [5:0] w_aluFunOut;
  logic       w_sign;
  logic       w_memRead;
  logic       w_memWrite;
  logic [1:0] w_memtoReg;
  logic       w_extOp;
  logic       w_luOp;

  // The only state in the block: irq is sampled once so decode sees a stable level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irqQ <= 1'b0;
    end else begin
      r_irqQ <= ctrl.irq;
    end
  end

  always_comb begin
    w_rArith   = 1'b0;
    w_rShift   = 1'b0;
    w_jr       = 1'b0;
    w_jalr     = 1'b0;
    w_iArith   = 1'b0;
    w_zeroExt  = 1'b0;
    w_lui      = 1'b0;
    w_lw       = 1'b0;
    w_sw       = 1'b0;
    w_branch   = 1'b0;
    w_j        = 1'b0;
    w_jal      = 1'b0;
    w_unsigned = 1'b0;
    w_aluFun   = ALU_ADD;
    case (ctrl.OpCode)
      6'h00: begin
        case (ctrl.Funct)
          6'h20: begin w_rArith = 1'b1; w_aluFun = ALU_ADD; end
          6'h21: begin w_rArith = 1'b1; w_aluFun = ALU_ADD; w_unsigned = 1'b1; end
          6'h22: begin w_rArith = 1'b1; w_aluFun = ALU_SUB; end
          6'h23: begin w_rArith = 1'b1; w_aluFun = ALU_SUB; w_unsigned = 1'b1; end
          6'h24: begin w_rArith = 1'b1; w_aluFun = ALU_AND; end
          6'h25: begin w_rArith = 1'b1; w_aluFun = ALU_OR;  end
          6'h26: begin w_rArith = 1'b1; w_aluFun = ALU_XOR; end
          6'h27: begin w_rArith = 1'b1; w_aluFun = ALU_NOR; end
          6'h2A: begin w_rArith = 1'b1; w_aluFun = ALU_LT;  end
          6'h2B: begin w_rArith = 1'b1; w_aluFun = ALU_LT;  w_unsigned = 1'b1; end
          6'h00: begin w_rShift = 1'b1; w_aluFun = ALU_SLL; end
          6'h02: begin w_rShift = 1'b1; w_aluFun = ALU_SRL; end
          6'h03: begin w_rShift = 1'b1; w_aluFun = ALU_SRA; end
          6'h08: w_jr   = 1'b1;
          6'h09: w_jalr = 1'b1;
          default: ;
        endcase
      end
      6'h08: begin w_iArith = 1'b1; w_aluFun = ALU_ADD; end
      6'h09: begin w_iArith = 1'b1; w_aluFun = ALU_ADD; w_unsigned = 1'b1; end
      6'h0A: begin w_iArith = 1'b1; w_aluFun = ALU_LT;  end
      6'h0B: begin w_iArith = 1'b1; w_aluFun = ALU_LT;  w_unsigned = 1'b1; end
      6'h0C: begin w_iArith = 1'b1; w_aluFun = ALU_AND; w_zeroExt = 1'b1; end
      6'h0D: begin w_iArith = 1'b1; w_aluFun = ALU_OR;  w_zeroExt = 1'b1; end
      6'h0F: w_lui = 1'b1;
      6'h23: w_lw  = 1'b1;
      6'h2B: w_sw  = 1'b1;
      6'h04: begin w_branch = 1'b1; w_aluFun = ALU_EQ;  end
      6'h05: begin w_branch = 1'b1; w_aluFun = ALU_NEQ; end
      6'h06: begin w_branch = 1'b1; w_aluFun = ALU_LEZ; end
      6'h07: begin w_branch = 1'b1; w_aluFun = ALU_GTZ; end
      6'h01: begin w_branch = 1'b1; w_aluFun = ALU_LTZ; end
      6'h02: w_j   = 1'b1;
      6'h03: w_jal = 1'b1;
      default: ;
    endcase
  end

  assign w_defined = w_rArith | w_rShift | w_jr | w_jalr | w_iArith | w_lui |
                     w_lw | w_sw | w_branch | w_j | w_jal;

  // Datapath selects per instruction class; the interrupt overrides everything touching PC, regfile and memory.
  always_comb begin
    w_pcSrc     = 3'd0;
    w_regDst    = 2'd0;
    w_regWrite  = 1'b0;
    w_aluSrc1   = 1'b0;
    w_aluSrc2   = 1'b0;
    w_aluFunOut = w_aluFun;
    w_sign      = ~w_unsigned;
    w_memRead   = 1'b0;
    w_memWrite  = 1'b0;
    w_memtoReg  = 2'd0;
    w_extOp     = 1'b0;
    w_luOp      = 1'b0;

    if (w_rArith || w_rShift) begin
      w_regWrite = 1'b1;
      w_aluSrc1  = w_rShift;
    end
    if (w_jr) begin
      w_pcSrc = 3'd3;
    end
    if (w_jalr) begin
      w_pcSrc    = 3'd3;
      w_regWrite = 1'b1;
      w_memtoReg = 2'd2;
    end
    if (w_iArith) begin
      w_regDst   = 2'd1;
      w_regWrite = 1'b1;
      w_aluSrc2  = 1'b1;
      w_extOp    = ~w_zeroExt;
    end
    if (w_lui) begin
      w_luOp     = 1'b1;
      w_regDst   = 2'd1;
      w_regWrite = 1'b1;
      w_aluSrc2  = 1'b1;
    end
    if (w_lw) begin
      w_memRead  = 1'b1;
      w_memtoReg = 2'd1;
      w_regDst   = 2'd1;
      w_regWrite = 1'b1;
      w_aluSrc2  = 1'b1;
      w_extOp    = 1'b1;
    end
    if (w_sw) begin
      w_memWrite = 1'b1;
      w_aluSrc2  = 1'b1;
      w_extOp    = 1'b1;
    end
    if (w_branch) begin
      w_pcSrc = 3'd1;
    end
    if (w_j) begin
      w_pcSrc = 3'd2;
    end
    if (w_jal) begin
      w_pcSrc    = 3'd2;
      w_regDst   = 2'd2;
      w_regWrite = 1'b1;
      w_memtoReg = 2'd2;
    end

`ifdef CONTROL_UNDEF_EXCEPTION_EN
    if (!w_defined) begin
      w_pcSrc    = 3'd5;
      w_regDst   = 2'd3;
      w_regWrite = 1'b1;
      w_memtoReg = 2'd2;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
    end
`else
    if (!w_defined) begin
      w_pcSrc    = 3'd0;
      w_regWrite = 1'b0;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
    end
`endif

    if (r_irqQ) begin
      w_pcSrc    = 3'd4;
      w_regDst   = 2'd3;
      w_regWrite = 1'b1;
      w_memtoReg = 2'd2;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
    end
  end

  assign ctrl.PCSrc    = w_pcSrc;
  assign ctrl.RegDst   = w_regDst;
  assign ctrl.RegWrite = w_regWrite;
  assign ctrl.ALUSrc1  = w_aluSrc1;
  assign ctrl.ALUSrc2  = w_aluSrc2;
  assign ctrl.ALUFun   = w_aluFunOut;
  assign ctrl.Sign     = w_sign;
  assign ctrl.MemRead  = w_memRead;
  assign ctrl.MemWrite = w_memWrite;
  assign ctrl.MemtoReg = w_memtoReg;
  assign ctrl.ExtOp    = w_extOp;
  assign ctrl.LuOp     = w_luOp;

endmodule

// File: tb/tb_control.sv
// Bench for control: directed reset/irq scenarios plus randomized instructions against an instruction-table reference model.
module tb_control;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND = 6'b011000, OR = 6'b011110;
  localparam logic [5:0] XOR = 6'b010110, NOR = 6'b010001, SLL = 6'b100000, SRL = 6'b100001;
  localparam logic [5:0] SRA = 6'b100011, EQ = 6'b110011, NEQ = 6'b110001, LT = 6'b110101;
  localparam logic [5:0] LEZ = 6'b111101, LTZ = 6'b111011, GTZ = 6'b111111;

  typedef struct packed {
    logic [2:0] pcSrc;
    logic [1:0] regDst;
    logic       regWrite;
    logic       aluSrc1;
    logic       aluSrc2;
    logic [5:0] aluFun;
    logic       sign;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memtoReg;
    logic       extOp;
    logic       luOp;
  } ctrlT;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic curIrq;

  control_if ctrlBus();

  control dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrlBus.slave)
  );

  always #5 clk = ~clk;

  // Expected decode for one instruction, written as a lookup of what each mnemonic does.
  function automatic ctrlT refModel(input logic [5:0] op, input logic [5:0] fn,
                                    input logic irqQ, output logic defined);
    ctrlT e;
    e = '0;
    e.aluFun = ADD;
    e.sign = 1'b1;
    defined = 1'b1;
    if (op == 6'h00) begin
      case (fn)
        6'h20: e.aluFun = ADD;
        6'h21: begin e.aluFun = ADD; e.sign = 1'b0; end
        6'h22: e.aluFun = SUB;
        6'h23: begin e.aluFun = SUB; e.sign = 1'b0; end
        6'h24: e.aluFun = AND;
        6'h25: e.aluFun = OR;
        6'h26: e.aluFun = XOR;
        6'h27: e.aluFun = NOR;
        6'h2A: e.aluFun = LT;
        6'h2B: begin e.aluFun = LT; e.sign = 1'b0; end
        6'h00: begin e.aluFun = SLL; e.aluSrc1 = 1'b1; end
        6'h02: begin e.aluFun = SRL; e.aluSrc1 = 1'b1; end
        6'h03: begin e.aluFun = SRA; e.aluSrc1 = 1'b1; end
        6'h08: e.pcSrc = 3'd3;
        6'h09: begin e.pcSrc = 3'd3; e.regWrite = 1'b1; e.memtoReg = 2'd2; end
        default: defined = 1'b0;
      endcase
      if (defined && fn != 6'h08 && fn != 6'h09) e.regWrite = 1'b1;
    end else begin
      case (op)
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
          e.regDst = 2'd1;
          e.regWrite = 1'b1;
          e.aluSrc2 = 1'b1;
          e.extOp = !(op == 6'h0C || op == 6'h0D);
          e.sign = !(op == 6'h09 || op == 6'h0B);
          if (op == 6'h0A || op == 6'h0B) e.aluFun = LT;
          else if (op == 6'h0C) e.aluFun = AND;
          else if (op == 6'h0D) e.aluFun = OR;
        end
        6'h0F: begin e.luOp = 1'b1; e.regDst = 2'd1; e.regWrite = 1'b1; e.aluSrc2 = 1'b1; end
        6'h23: begin
          e.memRead = 1'b1; e.memtoReg = 2'd1; e.regDst = 2'd1;
          e.regWrite = 1'b1; e.aluSrc2 = 1'b1; e.extOp = 1'b1;
        end
        6'h2B: begin e.memWrite = 1'b1; e.aluSrc2 = 1'b1; e.extOp = 1'b1; end
        6'h04: begin e.pcSrc = 3'd1; e.aluFun = EQ;  end
        6'h05: begin e.pcSrc = 3'd1; e.aluFun = NEQ; end
        6'h06: begin e.pcSrc = 3'd1; e.aluFun = LEZ; end
        6'h07: begin e.pcSrc = 3'd1; e.aluFun = GTZ; end
        6'h01: begin e.pcSrc = 3'd1; e.aluFun = LTZ; end
        6'h02: e.pcSrc = 3'd2;
        6'h03: begin e.pcSrc = 3'd2; e.regDst = 2'd2; e.regWrite = 1'b1; e.memtoReg = 2'd2; end
        default: defined = 1'b0;
      endcase
    end
`ifdef CONTROL_UNDEF_EXCEPTION_EN
    if (!defined) begin
      e.pcSrc = 3'd5; e.regDst = 2'd3; e.regWrite = 1'b1; e.memtoReg = 2'd2;
    end
`endif
    if (irqQ) begin
      e.pcSrc = 3'd4; e.regDst = 2'd3; e.regWrite = 1'b1;
      e.memtoReg = 2'd2; e.memRead = 1'b0; e.memWrite = 1'b0;
    end
    return e;
  endfunction

  function automatic ctrlT observed();
    ctrlT a;
    a.pcSrc    = ctrlBus.PCSrc;
    a.regDst   = ctrlBus.RegDst;
    a.regWrite = ctrlBus.RegWrite;
    a.aluSrc1  = ctrlBus.ALUSrc1;
    a.aluSrc2  = ctrlBus.ALUSrc2;
    a.aluFun   = ctrlBus.ALUFun;
    a.sign     = ctrlBus.Sign;
    a.memRead  = ctrlBus.MemRead;
    a.memWrite = ctrlBus.MemWrite;
    a.memtoReg = ctrlBus.MemtoReg;
    a.extOp    = ctrlBus.ExtOp;
    a.luOp     = ctrlBus.LuOp;
    return a;
  endfunction

  function automatic logic [9:0] keyFields(input ctrlT c);
    return {c.pcSrc, c.regDst, c.regWrite, c.memtoReg, c.memRead, c.memWrite};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Trap and interrupt paths only define the PC/regfile/memory fields, so only those are compared there.
  task automatic compareAll(input string tag, input logic irqQ);
    ctrlT exp;
    ctrlT act;
    logic defined;
    logic partial;
    exp = refModel(ctrlBus.OpCode, ctrlBus.Funct, irqQ, defined);
    act = observed();
    partial = irqQ;
`ifdef CONTROL_UNDEF_EXCEPTION_EN
    partial = partial | !defined;
`endif
    if (partial) checkOutput(tag, {22'd0, keyFields(act)}, {22'd0, keyFields(exp)});
    else         checkOutput(tag, {11'd0, act}, {11'd0, exp});
  endtask

  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic irqv);
    @(negedge clk);
    ctrlBus.OpCode = op;
    ctrlBus.Funct  = fn;
    ctrlBus.irq    = irqv;
    #1;
    compareAll({tag, "_comb"}, curIrq);
    @(posedge clk);
    curIrq = reset ? irqv : 1'b0;
    #1;
    compareAll({tag, "_clk"}, curIrq);
  endtask

  logic [5:0] validOps [19] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0A, 6'h0B, 6'h0F,
                                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03};
  logic [5:0] validFns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    logic       irqv;
    reset = 1'b0;
    curIrq = 1'b0;
    ctrlBus.OpCode = 6'h00;
    ctrlBus.Funct  = 6'h09;
    ctrlBus.irq    = 1'b1;
    #2;
    compareAll("reset_jalr", 1'b0);
    @(posedge clk);
    #1;
    compareAll("reset_irq_blocked", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    compareAll("release_no_irq_yet", 1'b0);
    @(posedge clk);
    curIrq = 1'b1;
    #1;
    compareAll("first_edge_irq", 1'b1);
    checkOutput("first_edge_pcsrc", {29'd0, ctrlBus.PCSrc}, 32'd4);

    applyStimulus("jalr",  6'h00, 6'h09, 1'b0);
    applyStimulus("jalr2", 6'h00, 6'h09, 1'b0);
    checkOutput("jalr_pcsrc", {29'd0, ctrlBus.PCSrc}, 32'd3);
    applyStimulus("lw",    6'h23, 6'h00, 1'b0);
    checkOutput("lw_alufun", {26'd0, ctrlBus.ALUFun}, 32'd0);
    applyStimulus("blez",  6'h06, 6'h00, 1'b0);
    checkOutput("blez_alufun", {26'd0, ctrlBus.ALUFun}, {26'd0, LEZ});
    applyStimulus("sra",   6'h00, 6'h03, 1'b0);
    applyStimulus("undef", 6'h3F, 6'h00, 1'b0);
`ifdef CONTROL_UNDEF_EXCEPTION_EN
    checkOutput("undef_pcsrc", {29'd0, ctrlBus.PCSrc}, 32'd5);
`else
    checkOutput("undef_pcsrc", {29'd0, ctrlBus.PCSrc}, 32'd0);
`endif

    applyStimulus("sw_irq", 6'h2B, 6'h00, 1'b1);
    checkOutput("sw_irq_memwrite", {31'd0, ctrlBus.MemWrite}, 32'd0);
    @(negedge clk);
    ctrlBus.irq = 1'b0;
    #1;
    reset = 1'b0;
    curIrq = 1'b0;
    #1;
    compareAll("async_reset_sw", 1'b0);
    checkOutput("async_reset_pcsrc", {29'd0, ctrlBus.PCSrc}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) op = validOps[$urandom_range(0, 18)];
      else op = 6'($urandom);
      if ($urandom_range(0, 3) != 0) fn = validFns[$urandom_range(0, 14)];
      else fn = 6'($urandom);
      irqv = ($urandom_range(0, 7) == 0);
      applyStimulus("rand", op, fn, irqv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 clk  input  1  system clock; only the irq sampling register uses it.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 OpCode  input  6  instruction[31:26].
REQ-004 Funct  input  6  instruction[5:0].
REQ-005 irq  input  1  external interrupt request, level-sensitive.
REQ-006 PCSrc  output  3  0 PC+4, 1 branch target, 2 jump target, 3 register (jr/jalr), 4 interrupt vector 0x80000004, 5 exception vector 0x80000008.
REQ-007 RegDst  output  2  0 rd, 1 rt, 2 $31, 3 $26 ($k0).
REQ-008 RegWrite  output  1  register file write enable.
REQ-009 ALUSrc1  output  1  1 selects shamt as ALU A, 0 selects rs.
REQ-010 ALUSrc2  output  1  1 selects extended immediate as ALU B, 0 selects rt.
REQ-011 ALUFun  output  6  ALU operation code.
REQ-012 Sign  output  1  1 signed compare/overflow, 0 unsigned.
REQ-013 MemRead, MemWrite  output  1 each  data memory strobes.
REQ-014 MemtoReg  output  2  0 ALU result, 1 memory data, 2 PC+4.
REQ-015 ExtOp  output  1  1 sign-extend, 0 zero-extend imm16.
REQ-016 LuOp  output  1  1 selects {imm16,16'b0}.

Function
REQ-017 irq SHALL be registered once on rising clk into irq_q; all decoding SHALL be combinational from OpCode, Funct and irq_q, with zero-cycle latency.
REQ-018 ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, PASS-A 011010, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
REQ-019 R-type (OpCode 00): add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, sll 00, srl 02, sra 03 -> RegDst 0, RegWrite 1, MemtoReg 0, ALUSrc2 0, PCSrc 0; ALUSrc1 1 only for sll/srl/sra.
REQ-020 jr (00/08) -> PCSrc 3, RegWrite 0; jalr (00/09) -> PCSrc 3, RegDst 0, RegWrite 1, MemtoReg 2.
REQ-021 I-type: addi 08, addiu 09, andi 0C, ori 0D, slti 0A, sltiu 0B -> RegDst 1, RegWrite 1, ALUSrc2 1, MemtoReg 0; ExtOp 0 for andi/ori, 1 otherwise; lui 0F -> LuOp 1, RegDst 1, RegWrite 1, ALUSrc2 1, ALUFun ADD, ALU A = $0 result path via ALU.
REQ-022 lw 23 -> MemRead 1, MemtoReg 1, RegDst 1, RegWrite 1, ALUSrc2 1, ExtOp 1, ALUFun ADD; sw 2B -> MemWrite 1, RegWrite 0, ALUSrc2 1, ExtOp 1, ALUFun ADD.
REQ-023 beq 04 EQ, bne 05 NEQ, blez 06 LEZ, bgtz 07 GTZ, bltz 01 LTZ -> PCSrc 1, RegWrite 0, ALUSrc2 0.
REQ-024 j 02 -> PCSrc 2, RegWrite 0; jal 03 -> PCSrc 2, RegDst 2, RegWrite 1, MemtoReg 2.
REQ-025 Sign SHALL be 0 for addu, subu, sltu, addiu, sltiu; 1 otherwise.
REQ-026 irq_q=1 SHALL override any instruction: PCSrc 4, RegDst 3, RegWrite 1, MemtoReg 2, MemRead 0, MemWrite 0.
REQ-027 Unlisted outputs per instruction SHALL be 0 (LuOp, ALUSrc1, MemRead, MemWrite default 0; ALUFun default ADD).

Reset
REQ-028 reset low SHALL clear irq_q to 0 immediately; decode outputs then reflect OpCode/Funct with no interrupt.
REQ-029 irq asserted during reset SHALL NOT take effect until the first rising clk after reset release.

Configuration
REQ-030 Macro CONTROL_UNDEF_EXCEPTION_EN defined: undefined OpCode/Funct SHALL give PCSrc 5, RegDst 3, RegWrite 1, MemtoReg 2, no memory access; irq_q still has priority. Not defined: undefined encodings SHALL decode as NOP (PCSrc 0, RegWrite 0, MemRead 0, MemWrite 0).

Verification
REQ-031 OpCode 00, Funct 09, irq 0 -> PCSrc 3, RegDst 0, RegWrite 1, MemtoReg 2, MemWrite 0.
REQ-032 OpCode 23 -> MemRead 1, MemtoReg 1, RegDst 1, ALUSrc2 1, ExtOp 1, ALUFun 000000.
REQ-033 OpCode 06 -> PCSrc 1, ALUFun 111101, RegWrite 0.
REQ-034 OpCode 00, Funct 03 -> ALUSrc1 1, ALUFun 100011, RegWrite 1.
REQ-035 irq 1 for one clk during sw (2B) -> next cycle PCSrc 4, RegDst 3, MemWrite 0; reset low -> PCSrc returns 0 without waiting for clk.
REQ-036 OpCode 3F with macro -> PCSrc 5, RegDst 3; without macro -> PCSrc 0, RegWrite 0.
